// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative signed/unsigned multiply/divide owning the HI/LO pair
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start, op, S, T    operation request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV) and operands
//   hi_we, lo_we       direct HI/LO writes of wr_data, honoured only while idle
//   flush              synchronous abort of an in-flight operation
//   busy, done         operation in flight / one-cycle completion pulse
//   div_zero           last completed divide had a zero divisor
//   HI, LO             result registers
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nx;
    logic                 is_div, neg, sgn_s, accept;
    logic [WIDTH-1:0]     a, b, smag, tmag, quo, rem;
    logic [2*WIDTH-1:0]   acc, acc_nx, prod;
    logic [WIDTH:0]       msum, trial;
    logic [CW-1:0]        cnt;

    assign busy = state != IDLE;

    always_comb begin
        accept   = state == IDLE && start && !flush;
        state_nx = flush ? IDLE :
                   state == IDLE ? (start ? RUN : IDLE) :
                   state == RUN  ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
    end

    // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top.
    // Divide keeps {remainder, dividend/quotient}; the shifted-out remainder bit joins the
    // trial subtraction, so trial[WIDTH] set means the divisor did not fit.
    always_comb begin
        smag   = op[0] && S[WIDTH-1] ? -S : S;
        tmag   = op[0] && T[WIDTH-1] ? -T : T;
        msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a} : '0);
        trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
        acc_nx = !is_div ? {msum, acc[WIDTH-1:1]} :
                 trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                 {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod   = neg ? -acc : acc;
        quo    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        // With a zero divisor the remainder ends up as the dividend magnitude, so restoring
        // the dividend sign reproduces the original S.
        rem    = sgn_s ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div   <= 1'b0;
            neg      <= 1'b0;
            sgn_s    <= 1'b0;
            a        <= '0;
            b        <= '0;
            acc      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            done <= state == FIX && !flush;
            if (state == IDLE && hi_we) HI <= wr_data;
            if (state == IDLE && lo_we) LO <= wr_data;
            if (accept) begin
                is_div   <= op[1];
                neg      <= op[0] && (S[WIDTH-1] ^ T[WIDTH-1]);
                sgn_s    <= op[0] && S[WIDTH-1];
                a        <= smag;
                b        <= tmag;
                acc      <= {{WIDTH{1'b0}}, op[1] ? smag : tmag};
                cnt      <= CW'(WIDTH);
                div_zero <= 1'b0;
            end
            if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !flush) begin
                if (is_div) begin
                    HI       <= rem;
                    LO       <= b == '0 ? acc[WIDTH-1:0] : quo;
                    div_zero <= b == '0;
                end else begin
                    {HI, LO} <= prod;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed bench with a cycle-level reference model for muldiv_hilo_unit
module tb_muldiv_hilo_unit;
    logic        clk = 0, reset = 1, start = 0, hi_we = 0, lo_we = 0, flush = 0;
    logic [1:0]  op = 0;
    logic [31:0] S = 0, T = 0, wr_data = 0;
    logic        busy, done, div_zero;
    logic [31:0] HI, LO;

    logic        reset8 = 1, start8 = 0;
    logic [1:0]  op8 = 0;
    logic [7:0]  s8 = 0, t8 = 0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .S(S), .T(T),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    muldiv_hilo_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op(op8), .S(s8), .T(t8),
        .hi_we(1'b0), .lo_we(1'b0), .wr_data(8'h00), .flush(1'b0),
        .busy(busy8), .done(done8), .div_zero(dz8), .HI(hi8), .LO(lo8)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: 64-bit integer multiply/divide straight from the operation rules.
    function automatic void calc(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t,
                                 output logic [31:0] h, output logic [31:0] l, output bit dz);
        longint ss, tt, r;
        ss = o[0] ? longint'($signed(s)) : longint'(s);
        tt = o[0] ? longint'($signed(t)) : longint'(t);
        dz = 0;
        if (!o[1]) begin
            r = ss * tt;
            {h, l} = r;
        end else if (t == 0) begin
            h = s;
            l = '1;
            dz = 1;
        end else begin
            r = ss % tt;
            h = r[31:0];
            r = ss / tt;
            l = r[31:0];
        end
    endfunction

    int          rem_cyc;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_dz, p_dz, p_div, m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_cyc = 0; m_hi = 0; m_lo = 0; m_dz = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (rem_cyc > 0) begin
                if (flush) rem_cyc = 0;
                else begin
                    rem_cyc--;
                    if (rem_cyc == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1;
                        if (p_div) m_dz = p_dz;
                    end
                end
            end else begin
                if (hi_we) m_hi = wr_data;
                if (lo_we) m_lo = wr_data;
                if (start && !flush) begin
                    calc(op, S, T, p_hi, p_lo, p_dz);
                    p_div = op[1];
                    m_dz = 0;
                    rem_cyc = 33;
                end
            end
        end
    end

    always @(negedge clk)
        if (!reset)
            chk("cycle", {busy, done, div_zero, HI, LO}, {rem_cyc != 0, m_done, m_dz, m_hi, m_lo});

    task automatic go(input logic [1:0] o, input logic [31:0] s, input logic [31:0] t, output int bc);
        op = o; S = s; T = t; start = 1;
        @(negedge clk);
        start = 0;
        bc = 0;
        while (busy && bc < 100) begin bc++; @(negedge clk); end
    endtask

    task automatic go8(input logic [1:0] o, input logic [7:0] s, input logic [7:0] t, output int bc);
        op8 = o; s8 = s; t8 = t; start8 = 1;
        @(negedge clk);
        start8 = 0;
        bc = 0;
        while (busy8 && bc < 100) begin bc++; @(negedge clk); end
    endtask

    initial begin
        int bc;
        bit seen;
        repeat (2) @(negedge clk);
        reset = 0; reset8 = 0;
        chk("reset_state", {busy, done, div_zero, HI, LO}, 0);

        go(2'b01, 32'hFFFFFFFD, 32'd5, bc);
        chk("mult_busy_cycles", bc, 33);
        chk("mult_done", done, 1);
        chk("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);

        go(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
        chk("multu_hilo", {HI, LO}, 64'hFFFFFFFE_00000001);
        go(2'b11, 32'hFFFFFFF9, 32'd2, bc);
        chk("b2b_div_busy", bc, 33);
        chk("div_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        go(2'b11, 32'd7, 32'hFFFFFFFE, bc);
        chk("div_negdivisor", {HI, LO}, 64'h00000001_FFFFFFFD);

        go(2'b10, 32'd100, 32'd0, bc);
        chk("divz_busy", bc, 33);
        chk("divz_hilo", {HI, LO}, 64'h00000064_FFFFFFFF);
        chk("divz_flag", div_zero, 1);
        op = 2'b00; S = 32'd3; T = 32'd4; start = 1;
        @(negedge clk);
        start = 0;
        chk("divz_cleared", div_zero, 0);
        bc = 0;
        while (busy && bc < 100) begin bc++; @(negedge clk); end
        chk("multu_small", {HI, LO}, 64'd12);

        hi_we = 1; wr_data = 32'h11;
        @(negedge clk);
        hi_we = 0; lo_we = 1; wr_data = 32'h22;
        @(negedge clk);
        lo_we = 0;
        op = 2'b10; S = 32'd9; T = 32'd2; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_busy", busy, 0);
        seen = 0;
        repeat (40) begin seen |= done; @(negedge clk); end
        chk("flush_no_done", seen, 0);
        chk("flush_hilo", {HI, LO}, 64'h00000011_00000022);

        op = 2'b00; S = 32'd6; T = 32'd7; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        hi_we = 1; wr_data = 32'hDEAD; start = 1; op = 2'b10; S = 32'd100; T = 32'd3;
        @(negedge clk);
        hi_we = 0; start = 0;
        bc = 5;
        while (busy && bc < 100) begin bc++; @(negedge clk); end
        chk("ignored_busy", bc, 33);
        chk("ignored_hilo", {HI, LO}, 64'd42);
        repeat (3) @(negedge clk);
        chk("not_queued", busy, 0);

        go8(2'b10, 8'd7, 8'd0, bc);
        chk("w8_divz", {dz8, hi8, lo8}, {1'b1, 8'h07, 8'hFF});
        go8(2'b11, 8'h80, 8'hFF, bc);
        chk("w8_ovf_busy", bc, 9);
        chk("w8_ovf_hilo", {done8, dz8, hi8, lo8}, {1'b1, 1'b0, 8'h00, 8'h80});
        op8 = 2'b10; s8 = 8'h37; t8 = 8'h05; start8 = 1;
        @(negedge clk);
        start8 = 0;
        repeat (3) @(negedge clk);
        chk("w8_running", busy8, 1);
        #1 reset8 = 1;
        #1 chk("w8_async_reset", {busy8, done8, dz8, hi8, lo8}, 0);
        @(negedge clk);
        reset8 = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
